// File: rtl/rs_multi_entry_pkg.sv
// Shared widths, opcode encodings and the reservation-station entry record.
package rs_multi_entry_pkg;
    localparam int TAG_W = 5;
    localparam int XLEN  = 32;
    localparam int OP_W  = 3;

    localparam logic [OP_W-1:0] OP_ALU = 3'b001;
    localparam logic [OP_W-1:0] OP_LD  = 3'b010;
    localparam logic [OP_W-1:0] OP_ST  = 3'b011;
    localparam logic [OP_W-1:0] OP_FP  = 3'b100;

    typedef logic [TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic            busy;
        logic [OP_W-1:0] op;
        rob_tag_t        t;
        rob_tag_t        t1;
        rob_tag_t        t2;
        logic [XLEN-1:0] v1;
        logic [XLEN-1:0] v2;
    } rs_entry_t;

    // Tag 0 means "value present", so it can never be woken by the CDB.
    function automatic logic tag_hit(input rob_tag_t src, input logic cdb_valid,
                                     input rob_tag_t cdb_tag);
        return cdb_valid && (cdb_tag != '0) && (src == cdb_tag);
    endfunction
endpackage

// File: rtl/rs_multi_entry_if.sv
// Dispatch, CDB, issue and status bundle between the pipeline and the reservation station.
interface rs_multi_entry_if
    import rs_multi_entry_pkg::*;
#(
    parameter int RS_DEPTH = 8
);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    // Handshakes: a transfer happens on a posedge where valid && ready are both 1;
    // valid never waits on ready, and ready is derived from registered state only.
    logic                disp_valid;
    logic                disp_ready;
    logic [OP_W-1:0]     disp_op;
    rob_tag_t            disp_tag;
    rob_tag_t            disp_t1;
    rob_tag_t            disp_t2;
    logic [XLEN-1:0]     disp_v1;
    logic [XLEN-1:0]     disp_v2;

    logic                cdb_valid;
    rob_tag_t            cdb_tag;
    logic [XLEN-1:0]     cdb_value;

    logic                issue_valid;
    logic                issue_ready;
    logic [OP_W-1:0]     issue_op;
    rob_tag_t            issue_tag;
    logic [XLEN-1:0]     issue_v1;
    logic [XLEN-1:0]     issue_v2;

    logic                flush;
    logic [RS_DEPTH-1:0] busy;
    logic [CNT_W-1:0]    free_count;

    modport master (
        output disp_valid, disp_op, disp_tag, disp_t1, disp_t2, disp_v1, disp_v2,
        output cdb_valid, cdb_tag, cdb_value, issue_ready, flush,
        input  disp_ready, issue_valid, issue_op, issue_tag, issue_v1, issue_v2,
        input  busy, free_count
    );

    modport slave (
        input  disp_valid, disp_op, disp_tag, disp_t1, disp_t2, disp_v1, disp_v2,
        input  cdb_valid, cdb_tag, cdb_value, issue_ready, flush,
        output disp_ready, issue_valid, issue_op, issue_tag, issue_v1, issue_v2,
        output busy, free_count
    );
endinterface

// File: rtl/rs_multi_entry_age_select.sv
// Age matrix over the entries plus a one-hot grant of the oldest ready entry.
module rs_multi_entry_age_select #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         alloc_en,
    input  logic [N-1:0] alloc_onehot,
    input  logic [N-1:0] ready,
    output logic [N-1:0] grant
);
    // age_q[i][j] == 1 means entry i is older than entry j.
    logic [N-1:0] age_q [N];
    logic [N-1:0] age_d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            age_d[i] = age_q[i];
        end
        if (flush) begin
            for (int i = 0; i < N; i++) begin
                age_d[i] = '0;
            end
        end else if (alloc_en) begin
            for (int k = 0; k < N; k++) begin
                if (alloc_onehot[k]) begin
                    age_d[k] = '0;
                    for (int i = 0; i < N; i++) begin
                        age_d[i][k] = (i != k);
                    end
                end
            end
        end
    end

    // Stale bits left by freed entries are harmless: they only matter while ready[j] is 1.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < N; j++) begin
                if ((j != i) && ready[j] && age_q[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
endmodule

// File: rtl/rs_multi_entry.sv
// Reservation station: entry array, free-slot encoder, CDB wakeup/bypass and oldest-ready issue.
module rs_multi_entry
    import rs_multi_entry_pkg::*;
#(
    parameter int RS_DEPTH = 8
) (
    input logic              clock,
    input logic              reset,
    rs_multi_entry_if.slave  bus
);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    rs_entry_t ent_q [RS_DEPTH];
    rs_entry_t ent_d [RS_DEPTH];

    logic [RS_DEPTH-1:0] busy_vec;
    logic [RS_DEPTH-1:0] ready_vec;
    logic [RS_DEPTH-1:0] free_onehot;
    logic [RS_DEPTH-1:0] grant;
    logic                any_free;
    logic                disp_fire;
    logic                issue_fire;
    logic                found;
    logic [CNT_W-1:0]    free_cnt;
    logic [OP_W-1:0]     sel_op;
    rob_tag_t            sel_tag;
    logic [XLEN-1:0]     sel_v1;
    logic [XLEN-1:0]     sel_v2;

    always_comb begin
        busy_vec    = '0;
        ready_vec   = '0;
        free_onehot = '0;
        found       = 1'b0;
        free_cnt    = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && (ent_q[i].t1 == '0) && (ent_q[i].t2 == '0);
            if (!ent_q[i].busy) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!found) begin
                    free_onehot[i] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
        any_free = found;
    end

    rs_multi_entry_age_select #(.N(RS_DEPTH)) u_age_select (
        .clock        (clock),
        .reset        (reset),
        .flush        (bus.flush),
        .alloc_en     (disp_fire),
        .alloc_onehot (free_onehot),
        .ready        (ready_vec),
        .grant        (grant)
    );

    // AND-OR mux: all issue data reads as zero when nothing is granted.
    always_comb begin
        sel_op  = '0;
        sel_tag = '0;
        sel_v1  = '0;
        sel_v2  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) begin
                sel_op  = sel_op  | ent_q[i].op;
                sel_tag = sel_tag | ent_q[i].t;
                sel_v1  = sel_v1  | ent_q[i].v1;
                sel_v2  = sel_v2  | ent_q[i].v2;
            end
        end
    end

    assign disp_fire  = bus.disp_valid && any_free && !bus.flush;
    assign issue_fire = (|grant) && bus.issue_ready && !bus.flush;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy) begin
                if (tag_hit(ent_q[i].t1, bus.cdb_valid, bus.cdb_tag)) begin
                    ent_d[i].t1 = '0;
                    ent_d[i].v1 = bus.cdb_value;
                end
                if (tag_hit(ent_q[i].t2, bus.cdb_valid, bus.cdb_tag)) begin
                    ent_d[i].t2 = '0;
                    ent_d[i].v2 = bus.cdb_value;
                end
            end
            if (issue_fire && grant[i]) begin
                ent_d[i].busy = 1'b0;
            end
            if (disp_fire && free_onehot[i]) begin
                ent_d[i].busy = 1'b1;
                ent_d[i].op   = bus.disp_op;
                ent_d[i].t    = bus.disp_tag;
                if (tag_hit(bus.disp_t1, bus.cdb_valid, bus.cdb_tag)) begin
                    ent_d[i].t1 = '0;
                    ent_d[i].v1 = bus.cdb_value;
                end else begin
                    ent_d[i].t1 = bus.disp_t1;
                    ent_d[i].v1 = bus.disp_v1;
                end
                if (tag_hit(bus.disp_t2, bus.cdb_valid, bus.cdb_tag)) begin
                    ent_d[i].t2 = '0;
                    ent_d[i].v2 = bus.cdb_value;
                end else begin
                    ent_d[i].t2 = bus.disp_t2;
                    ent_d[i].v2 = bus.disp_v2;
                end
            end
            if (bus.flush) begin
                ent_d[i].busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign bus.disp_ready  = any_free;
    assign bus.issue_valid = |grant;
    assign bus.issue_op    = sel_op;
    assign bus.issue_tag   = sel_tag;
    assign bus.issue_v1    = sel_v1;
    assign bus.issue_v2    = sel_v2;
    assign bus.busy        = busy_vec;
    assign bus.free_count  = free_cnt;
endmodule
